// File: rtl/seq_alu_if.sv
// Request/result bundle for seq_alu.
//   Handshakes: a request transfers on a rising edge where in_valid && in_ready.
//   A result transfers on a rising edge where out_valid && out_ready.
//   Once out_valid is high, port_o/n/z/v stay stable until that result transfer.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluop;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] port_o;
  logic             n;
  logic             z;
  logic             v;

  modport master (
    output in_valid, aluop, port_a, port_b, out_ready,
    input  in_ready, out_valid, port_o, n, z, v
  );

  modport slave (
    input  in_valid, aluop, port_a, port_b, out_ready,
    output in_ready, out_valid, port_o, n, z, v
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL
// (shift-add) and DIVU/REMU (restoring divider), each taking WIDTH iterations.
// FSM state is visible on dbg_state (0 IDLE, 1 BUSY, 2 DONE).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       CLK,
  input  logic       nRST,
  seq_alu_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] wa_q, wb_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             n_q, z_q, v_q;

  logic             multi, last;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, res_c;
  logic             v_c;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] acc_n, wa_n, wb_n, fin_c;

  assign multi = (bus.aluop == OP_MUL) || (bus.aluop == OP_DIVU) || (bus.aluop == OP_REMU);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // in_ready is masked by nRST so nothing looks acceptable during a reset cycle.
  assign bus.in_ready  = (state_q == IDLE) && nRST;
  assign bus.out_valid = (state_q == DONE);
  assign bus.port_o    = res_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.v         = v_q;
  assign dbg_state     = state_q;

  // Single-cycle result and overflow straight from the request operands.
  always_comb begin
    shamt = bus.port_b[SHW-1:0];
    sum   = bus.port_a + bus.port_b;
    diff  = bus.port_a - bus.port_b;
    res_c = '0;
    v_c   = 1'b0;
    case (bus.aluop)
      OP_SLL:  res_c = bus.port_a << shamt;
      OP_SRL:  res_c = bus.port_a >> shamt;
      OP_ADD: begin
        res_c = sum;
        v_c   = (bus.port_a[WIDTH-1] == bus.port_b[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff;
        v_c   = (bus.port_a[WIDTH-1] != bus.port_b[WIDTH-1]) &&
                (diff[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      OP_AND:  res_c = bus.port_a & bus.port_b;
      OP_OR:   res_c = bus.port_a | bus.port_b;
      OP_XOR:  res_c = bus.port_a ^ bus.port_b;
      OP_NOR:  res_c = ~(bus.port_a | bus.port_b);
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.port_a) < $signed(bus.port_b))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (bus.port_a < bus.port_b)};
      OP_SRA:  res_c = $signed(bus.port_a) >>> shamt;
      default: res_c = '0;
    endcase
  end

  // One iteration step. MUL: acc += mcand when multiplier LSB set.
  // DIVU/REMU: wa holds the dividend shifting out / quotient shifting in,
  // acc holds the partial remainder. Divisor 0 naturally yields all-ones / port_a.
  always_comb begin
    acc_n  = acc_q;
    wa_n   = wa_q;
    wb_n   = wb_q;
    div_sh = {acc_q, wa_q[WIDTH-1]};
    div_ge = (div_sh >= {1'b0, wb_q});
    if (op_q == OP_MUL) begin
      if (wb_q[0]) acc_n = acc_q + wa_q;
      wa_n = wa_q << 1;
      wb_n = wb_q >> 1;
    end else begin
      acc_n = div_ge ? (div_sh[WIDTH-1:0] - wb_q) : div_sh[WIDTH-1:0];
      wa_n  = {wa_q[WIDTH-2:0], div_ge};
    end
    fin_c = (op_q == OP_DIVU) ? wa_n : acc_n;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: DONE is entered on the edge performing the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = multi ? BUSY : DONE;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration registers and the held result/flags.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      op_q  <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b1;
      v_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.aluop;
            wa_q  <= bus.port_a;
            wb_q  <= bus.port_b;
            acc_q <= '0;
            cnt_q <= '0;
            if (!multi) begin
              res_q <= res_c;
              n_q   <= res_c[WIDTH-1];
              z_q   <= (res_c == '0);
              v_q   <= v_c;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_n;
          wa_q  <= wa_n;
          wb_q  <= wb_n;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cnt_q <= '0;
            res_q <= fin_c;
            n_q   <= fin_c[WIDTH-1];
            z_q   <= (fin_c == '0);
            v_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32: vector table, random ops against a
// reference model, and hand sequences for latency, backpressure and reset.
module tb_seq_alu;
  localparam int W  = 32;
  localparam int EW = W + 3;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         v;
  } vec_t;

  logic       clk;
  logic       nrst;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;
  logic [EW-1:0] exp_q[$];
  vec_t       tbl[$];

  seq_alu_if #(.WIDTH(W)) bus();

  seq_alu #(.WIDTH(W)) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [W-1:0] res, input logic v);
    return {res[W-1], (res == '0), v, res};
  endfunction

  // Reference model for random stimulus.
  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         v;
    int           sh;
    sh = int'(b[4:0]);
    v  = 1'b0;
    case (op)
      4'd0:  r = a << sh;
      4'd1:  r = a >> sh;
      4'd2:  begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd3:  begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = $signed(a) >>> sh;
      4'd11: r = a * b;
      4'd12: r = (b == 0) ? '1 : a / b;
      4'd13: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return pack_exp(r, v);
  endfunction

  // scoreboard consumer: pops one expectation per result transfer
  task automatic monitor();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (nrst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h, expected no result", bus.port_o);
        end else begin
          e = exp_q.pop_front();
          check("result{n,z,v,o}", {bus.n, bus.z, bus.v, bus.port_o}, e);
        end
      end
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.in_ready && k < 200) begin
      step();
      k++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ready: got in_ready 0 after %0d cycles, expected 1", k);
    end
  endtask

  // driver: apply one op, scramble inputs while it runs, check latency and busy time
  task automatic timed_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [EW-1:0] e);
    int lat, low, exp_lat;
    exp_lat = (op == 4'd11 || op == 4'd12 || op == 4'd13) ? W + 1 : 1;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.aluop    = op;
    bus.port_a   = a;
    bus.port_b   = b;
    exp_q.push_back(e);
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    low = 0;
    while (!bus.in_ready && low < 200) begin
      if (bus.out_valid) begin
        if (lat == 0) lat = low + 1;
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.aluop    = 4'($urandom_range(0, 15));
        bus.port_a   = $urandom;
        bus.port_b   = $urandom;
      end
      low++;
      step();
    end
    bus.in_valid = 1'b0;
    check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
    check($sformatf("ready_low op%0d", op), 64'(low), 64'(exp_lat));
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    logic         seen;
    n_vec = 0;
    n_err = 0;
    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.aluop     = 4'd0;
    bus.port_a    = '0;
    bus.port_b    = '0;
    bus.out_ready = 1'b1;

    tbl.push_back(vec_t'{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
    tbl.push_back(vec_t'{4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd10, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0});
    tbl.push_back(vec_t'{4'd10, 32'h40000000, 32'h00000004, 32'h04000000, 1'b0});
    tbl.push_back(vec_t'{4'd0,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0});
    tbl.push_back(vec_t'{4'd1,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0});
    tbl.push_back(vec_t'{4'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0});
    tbl.push_back(vec_t'{4'd5,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0});
    tbl.push_back(vec_t'{4'd6,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0});
    tbl.push_back(vec_t'{4'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    tbl.push_back(vec_t'{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
    tbl.push_back(vec_t'{4'd8,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    tbl.push_back(vec_t'{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1});
    tbl.push_back(vec_t'{4'd3,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    tbl.push_back(vec_t'{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    tbl.push_back(vec_t'{4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd11, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b0});
    tbl.push_back(vec_t'{4'd12, 32'd100,      32'd7,        32'd14,       1'b0});
    tbl.push_back(vec_t'{4'd13, 32'd100,      32'd7,        32'd2,        1'b0});
    tbl.push_back(vec_t'{4'd12, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0});
    tbl.push_back(vec_t'{4'd13, 32'd9,        32'd0,        32'd9,        1'b0});
    tbl.push_back(vec_t'{4'd13, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0});
    tbl.push_back(vec_t'{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0});
    tbl.push_back(vec_t'{4'd14, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0});
    tbl.push_back(vec_t'{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});

    fork
      monitor();
    join_none

    // reset state, including in_ready held low while nRST is low
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_port_o", 64'(bus.port_o), 64'd0);
    check("rst_flags{n,z,v}", 64'({bus.n, bus.z, bus.v}), 64'(3'b010));
    check("rst_state", 64'(dbg_state), 64'd0);
    nrst = 1'b1;
    #1;
    check("ready_after_release", 64'(bus.in_ready), 64'd1);

    // vector table
    foreach (tbl[i]) begin
      timed_op(tbl[i].op, tbl[i].a, tbl[i].b, pack_exp(tbl[i].res, tbl[i].v));
    end

    // random ops against the model
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      timed_op(rop, ra, rb, model(rop, ra, rb));
    end

    // backpressure: result and flags hold, in_valid pulses ignored
    bus.out_ready = 1'b0;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.aluop    = 4'd2;
    bus.port_a   = 32'h7FFFFFFF;
    bus.port_b   = 32'h00000001;
    exp_q.push_back(pack_exp(32'h80000000, 1'b1));
    step();
    bus.in_valid = 1'b0;
    check("bp_first_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'(i % 2);
      bus.aluop    = 4'($urandom_range(0, 15));
      bus.port_a   = $urandom;
      bus.port_b   = $urandom;
      step();
      check("bp_hold{valid,ready,n,z,v,o}",
            64'({bus.out_valid, bus.in_ready, bus.n, bus.z, bus.v, bus.port_o}),
            64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80000000}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);

    // reset in the middle of a DIVU: discarded with no output
    wait_ready();
    bus.in_valid = 1'b1;
    bus.aluop    = 4'd12;
    bus.port_a   = 32'd100;
    bus.port_b   = 32'd7;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    check("mid_div_state", 64'(dbg_state), 64'd1);
    nrst = 1'b0;
    step();
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_port_o", 64'(bus.port_o), 64'd0);
    check("rst_mid_flags{n,z,v}", 64'({bus.n, bus.z, bus.v}), 64'(3'b010));
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
    nrst = 1'b1;
    #1;
    check("rst_mid_release_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_stale_result", 64'(seen), 64'd0);

    // block still works after the mid-op reset
    timed_op(4'd12, 32'd100, 32'd7, pack_exp(32'd14, 1'b0));

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
